// File: rtl/keypad_code_lock_pkg.sv
// Shared key codes, FSM state encodings and key classification for the keypad code lock.
package lock_pkg;

    localparam logic [3:0] KEY_ENTER = 4'hA;
    localparam logic [3:0] KEY_CLEAR = 4'hB;
    localparam logic [3:0] KEY_SET   = 4'hC;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_ENTRY    = 3'd1;
    localparam logic [2:0] ST_UNLOCKED = 3'd2;
    localparam logic [2:0] ST_SET_CODE = 3'd3;
    localparam logic [2:0] ST_LOCKOUT  = 3'd4;

    function automatic logic is_digit(input logic [3:0] k);
        return k <= 4'd9;
    endfunction

endpackage

// File: rtl/keypad_code_lock_if.sv
// Single-cycle key event link from the keypad encoder to the code lock.
interface keypad_code_lock_if;

    logic       key_valid;
    logic [3:0] key_code;

    modport master (output key_valid, output key_code);
    modport slave  (input  key_valid, input  key_code);

endinterface

// File: rtl/keypad_code_lock_buffer.sv
// Shift-in digit buffer with saturating count, overflow flag and compare against a supplied code.
module code_buffer
    import lock_pkg::*;
#(
    parameter int unsigned CODE_LEN = 4
) (
    input  logic                  clk_in,
    input  logic                  rst_n,
    input  logic                  clear_i,
    input  logic                  shift_i,
    input  logic [3:0]            digit_i,
    input  logic [CODE_LEN*4-1:0] cmp_code_i,
    output logic [CODE_LEN*4-1:0] buf_o,
    output logic [3:0]            count_o,
    output logic                  full_ok_o,
    output logic                  match_o
);

    localparam int unsigned W = CODE_LEN * 4;
    localparam logic [3:0]  LEN_W = 4'(CODE_LEN);

    logic [W-1:0] buf_q, buf_d;
    logic [3:0]   cnt_q, cnt_d;
    logic         ovf_q, ovf_d;

    always_comb begin
        buf_d = buf_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (clear_i) begin
            buf_d = '0;
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (shift_i) begin
            // A full buffer keeps its contents; the extra digit only poisons the entry.
            if (cnt_q < LEN_W) begin
                buf_d = (buf_q << 4) | W'(digit_i);
                cnt_d = cnt_q + 4'd1;
            end else begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            buf_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            buf_q <= buf_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign buf_o     = buf_q;
    assign count_o   = cnt_q;
    assign full_ok_o = (cnt_q == LEN_W) && !ovf_q;
    assign match_o   = full_ok_o && (buf_q == cmp_code_i);

endmodule

// File: rtl/keypad_code_lock.sv
// Door-lock code-entry FSM: digit collection, unlock timing, failure lockout and code change.
module keypad_code_lock
    import lock_pkg::*;
#(
    parameter int unsigned CODE_LEN       = 4,
    parameter logic [31:0] DEFAULT_CODE   = 32'h0000_1234,
    parameter int unsigned MAX_FAIL       = 3,
    parameter logic [27:0] UNLOCK_CYCLES  = 28'd5000,
    parameter logic [27:0] LOCKOUT_CYCLES = 28'd30000,
    parameter logic [27:0] TIMEOUT_CYCLES = 28'd10000
) (
    input  logic                     clk_in,
    input  logic                     rst_n,
    keypad_code_lock_if.slave        key_if,
    output logic                     unlock,
    output logic                     fail_pulse,
    output logic                     lockout,
    output logic                     code_changed,
    output logic                     entry_error,
    output logic [3:0]               digit_count
);

    localparam int unsigned W = CODE_LEN * 4;
    localparam logic [3:0]  MAX_FAIL_W = 4'(MAX_FAIL);

    logic [2:0]   state_q, state_d;
    logic [27:0]  timer_q, timer_d, timer_inc;
    logic [3:0]   fail_q, fail_d, fail_inc;
    logic [W-1:0] code_q, code_d;
    logic         fail_pulse_q, fail_pulse_d;
    logic         changed_q, changed_d;
    logic         error_q, error_d;

    logic         buf_clear, buf_shift, buf_full_ok, buf_match;
    logic [W-1:0] buf_val;

    logic key_digit, key_enter, key_clear, key_set;

    assign key_digit = key_if.key_valid && is_digit(key_if.key_code);
    assign key_enter = key_if.key_valid && (key_if.key_code == KEY_ENTER);
    assign key_clear = key_if.key_valid && (key_if.key_code == KEY_CLEAR);
    assign key_set   = key_if.key_valid && (key_if.key_code == KEY_SET);

    assign timer_inc = (timer_q == '1) ? timer_q : timer_q + 28'd1;
    assign fail_inc  = (fail_q == '1) ? fail_q : fail_q + 4'd1;

    code_buffer #(.CODE_LEN(CODE_LEN)) u_buf (
        .clk_in     (clk_in),
        .rst_n      (rst_n),
        .clear_i    (buf_clear),
        .shift_i    (buf_shift),
        .digit_i    (key_if.key_code),
        .cmp_code_i (code_q),
        .buf_o      (buf_val),
        .count_o    (digit_count),
        .full_ok_o  (buf_full_ok),
        .match_o    (buf_match)
    );

    always_comb begin
        state_d      = state_q;
        timer_d      = timer_inc;
        fail_d       = fail_q;
        code_d       = code_q;
        fail_pulse_d = 1'b0;
        changed_d    = 1'b0;
        error_d      = 1'b0;
        buf_clear    = 1'b0;
        buf_shift    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                timer_d = '0;
                if (key_digit) begin
                    buf_shift = 1'b1;
                    state_d   = ST_ENTRY;
                end else if (key_enter) begin
                    fail_pulse_d = 1'b1;
                    fail_d       = fail_inc;
                    if (fail_inc >= MAX_FAIL_W) state_d = ST_LOCKOUT;
                end
            end
            ST_ENTRY, ST_SET_CODE: begin
                // Timer expiry outranks any key arriving on the same cycle.
                if (timer_q == TIMEOUT_CYCLES - 28'd1) begin
                    buf_clear = 1'b1;
                    state_d   = ST_IDLE;
                    timer_d   = '0;
                end else if (key_digit) begin
                    buf_shift = 1'b1;
                    timer_d   = '0;
                end else if (key_clear) begin
                    buf_clear = 1'b1;
                    state_d   = ST_IDLE;
                    timer_d   = '0;
                end else if (key_enter) begin
                    buf_clear = 1'b1;
                    timer_d   = '0;
                    state_d   = ST_IDLE;
                    if (state_q == ST_SET_CODE) begin
                        if (buf_full_ok) begin
                            code_d    = buf_val;
                            changed_d = 1'b1;
                        end else begin
                            error_d = 1'b1;
                        end
                    end else if (buf_match) begin
                        state_d = ST_UNLOCKED;
                        fail_d  = '0;
                    end else begin
                        fail_pulse_d = 1'b1;
                        fail_d       = fail_inc;
                        if (fail_inc >= MAX_FAIL_W) state_d = ST_LOCKOUT;
                    end
                end
            end
            ST_UNLOCKED: begin
                if (timer_q == UNLOCK_CYCLES - 28'd1) begin
                    state_d = ST_IDLE;
                    timer_d = '0;
                end else if (key_clear) begin
                    state_d = ST_IDLE;
                    timer_d = '0;
                end else if (key_set) begin
                    state_d = ST_SET_CODE;
                    timer_d = '0;
                end
            end
            ST_LOCKOUT: begin
                if (timer_q == LOCKOUT_CYCLES - 28'd1) begin
                    state_d = ST_IDLE;
                    timer_d = '0;
                    fail_d  = '0;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                timer_d   = '0;
                buf_clear = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            timer_q      <= '0;
            fail_q       <= '0;
            code_q       <= DEFAULT_CODE[W-1:0];
            fail_pulse_q <= 1'b0;
            changed_q    <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            fail_q       <= fail_d;
            code_q       <= code_d;
            fail_pulse_q <= fail_pulse_d;
            changed_q    <= changed_d;
            error_q      <= error_d;
        end
    end

    assign unlock       = (state_q == ST_UNLOCKED);
    assign lockout      = (state_q == ST_LOCKOUT);
    assign fail_pulse   = fail_pulse_q;
    assign code_changed = changed_q;
    assign entry_error  = error_q;

endmodule

// File: tb/tb_keypad_code_lock.sv
// Scoreboard bench for keypad_code_lock: expected output events are queued as keys are driven.
module tb_keypad_code_lock;
    import lock_pkg::*;

    localparam int unsigned EV_UNLOCK  = 1;
    localparam int unsigned EV_FAIL    = 2;
    localparam int unsigned EV_LOCKOUT = 3;
    localparam int unsigned EV_CHANGED = 4;
    localparam int unsigned EV_ERROR   = 5;

    logic       clk_in = 1'b0;
    logic       rst_n  = 1'b0;
    logic       unlock, fail_pulse, lockout, code_changed, entry_error;
    logic [3:0] digit_count;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned exp_q[$];
    logic        unlock_prev  = 1'b0;
    logic        lockout_prev = 1'b0;
    logic [3:0]  lock_seq [5];

    keypad_code_lock_if kif();

    keypad_code_lock #(
        .UNLOCK_CYCLES  (28'd20),
        .LOCKOUT_CYCLES (28'd50),
        .TIMEOUT_CYCLES (28'd30)
    ) dut (
        .clk_in       (clk_in),
        .rst_n        (rst_n),
        .key_if       (kif.slave),
        .unlock       (unlock),
        .fail_pulse   (fail_pulse),
        .lockout      (lockout),
        .code_changed (code_changed),
        .entry_error  (entry_error),
        .digit_count  (digit_count)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    task automatic sb_pop(input string tag, input int unsigned ev);
        if (exp_q.size() == 0) chk({tag, "_unexpected"}, ev, 0);
        else chk(tag, ev, exp_q.pop_front());
    endtask

    // Presses are issued at a falling edge and held for exactly one rising edge.
    task automatic press(input logic [3:0] k);
        kif.key_valid = 1'b1;
        kif.key_code  = k;
        @(negedge clk_in);
        kif.key_valid = 1'b0;
    endtask

    task automatic send_keys(input logic [31:0] keys, input int unsigned n);
        for (int unsigned i = n; i > 0; i--) press(keys[(i-1)*4 +: 4]);
    endtask

    task automatic idle(input int unsigned n);
        repeat (n) @(negedge clk_in);
    endtask

    always @(negedge clk_in) begin
        if (rst_n) begin
            if (fail_pulse)               sb_pop("ev_fail", EV_FAIL);
            if (lockout && !lockout_prev) sb_pop("ev_lockout", EV_LOCKOUT);
            if (unlock && !unlock_prev)   sb_pop("ev_unlock", EV_UNLOCK);
            if (code_changed)             sb_pop("ev_changed", EV_CHANGED);
            if (entry_error)              sb_pop("ev_error", EV_ERROR);
        end
        unlock_prev  = unlock;
        lockout_prev = lockout;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

    initial begin
        int unsigned cnt;
        kif.key_valid = 1'b0;
        kif.key_code  = 4'h0;
        lock_seq = '{4'h1, 4'h2, 4'h3, 4'h4, KEY_ENTER};

        idle(3);
        chk("rst_unlock", unlock, 0);
        chk("rst_lockout", lockout, 0);
        chk("rst_fail", fail_pulse, 0);
        chk("rst_changed", code_changed, 0);
        chk("rst_error", entry_error, 0);
        chk("rst_count", digit_count, 0);
        rst_n = 1'b1;
        idle(1);

        // correct code, with an ignored key mixed in
        send_keys(32'h1F2, 3);
        chk("count_ignored", digit_count, 2);
        send_keys(32'h34, 2);
        chk("count_full", digit_count, 4);
        exp_q.push_back(EV_UNLOCK);
        press(KEY_ENTER);
        chk("count_after_enter", digit_count, 0);
        cnt = 0;
        for (int i = 0; i < 25; i++) begin
            if (unlock) cnt++;
            @(negedge clk_in);
        end
        chk("unlock_len", cnt, 20);

        // three failures -> lockout; correct code during lockout is ignored
        for (int i = 0; i < 3; i++) begin
            send_keys(32'h1235, 4);
            exp_q.push_back(EV_FAIL);
            if (i == 2) exp_q.push_back(EV_LOCKOUT);
            press(KEY_ENTER);
        end
        cnt = 0;
        for (int i = 0; i < 60; i++) begin
            if (lockout) cnt++;
            if (i >= 2 && i < 7) begin
                kif.key_valid = 1'b1;
                kif.key_code  = lock_seq[i-2];
            end else begin
                kif.key_valid = 1'b0;
            end
            @(negedge clk_in);
        end
        kif.key_valid = 1'b0;
        chk("lockout_len", cnt, 50);
        exp_q.push_back(EV_UNLOCK);
        send_keys(32'h1234A, 5);
        press(KEY_CLEAR);
        chk("clear_relock", unlock, 0);

        // overflow, short entry and empty ENTER all fail
        send_keys(32'h12345, 5);
        chk("count_saturate", digit_count, 4);
        exp_q.push_back(EV_FAIL);
        press(KEY_ENTER);
        exp_q.push_back(EV_FAIL);
        send_keys(32'h12A, 3);
        exp_q.push_back(EV_UNLOCK);
        send_keys(32'h1234A, 5);
        press(KEY_CLEAR);
        exp_q.push_back(EV_FAIL);
        press(KEY_ENTER);

        // partial entry discarded by timeout
        press(4'h1);
        idle(29);
        chk("timeout_pre", digit_count, 1);
        idle(1);
        chk("timeout_post", digit_count, 0);
        exp_q.push_back(EV_FAIL);
        send_keys(32'h234A, 4);
        exp_q.push_back(EV_UNLOCK);
        send_keys(32'h1234A, 5);

        // code change while unlocked
        press(KEY_SET);
        chk("set_relock", unlock, 0);
        send_keys(32'h9876, 4);
        exp_q.push_back(EV_CHANGED);
        press(KEY_ENTER);
        exp_q.push_back(EV_FAIL);
        send_keys(32'h1234A, 5);
        exp_q.push_back(EV_UNLOCK);
        send_keys(32'h9876A, 5);
        press(KEY_SET);
        send_keys(32'h98, 2);
        exp_q.push_back(EV_ERROR);
        press(KEY_ENTER);
        exp_q.push_back(EV_UNLOCK);
        send_keys(32'h9876A, 5);

        // reset mid-unlock restores the default code
        idle(3);
        rst_n = 1'b0;
        #1;
        chk("reset_unlock", unlock, 0);
        @(negedge clk_in);
        rst_n = 1'b1;
        idle(1);
        chk("reset_count", digit_count, 0);
        exp_q.push_back(EV_UNLOCK);
        send_keys(32'h1234A, 5);
        press(KEY_CLEAR);
        idle(2);

        chk("sb_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/keypad_code_lock.md
Name: keypad_code_lock

Overview:
- Consumer end of the debounced-button pulse interface. It takes single-cycle key events produced by the button debouncers and key encoder, and runs the door-lock code-entry state machine.
- It collects digits and compares them against a stored code, then drives the unlock output. It also enforces a failure lockout and supports changing the code while the door is unlocked.
- It sits between the button/keypad front end and the door actuator/LED/buzzer drivers.

Parameters:
- CODE_LEN, 4, number of digits in the code (1..8).
- DEFAULT_CODE, 32'h0000_1234, code loaded at reset; low CODE_LEN*4 bits used, one BCD nibble per digit, first digit in the most significant used nibble.
- MAX_FAIL, 3, consecutive failed attempts that trigger lockout (1..15).
- UNLOCK_CYCLES, 28'd5000, clk_in cycles the unlock output stays high.
- LOCKOUT_CYCLES, 28'd30000, clk_in cycles of lockout.
- TIMEOUT_CYCLES, 28'd10000, idle cycles between keys before a partial entry is discarded.

Ports:
- clk_in  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- key_valid  input  1  single-cycle key event strobe.
- key_code  input  4  key code: 0-9 digit, 4'hA ENTER, 4'hB CLEAR, 4'hC SET; all others ignored.
- unlock  output  1  door release, level.
- fail_pulse  output  1  one-cycle pulse on a rejected code.
- lockout  output  1  high while in LOCKOUT.
- code_changed  output  1  one-cycle pulse when a new code is stored.
- entry_error  output  1  one-cycle pulse on a bad-length SET entry.
- digit_count  output  4  digits currently buffered (display feedback).

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE; stored code = DEFAULT_CODE.
  - Buffer, digit_count, fail counter and timers are cleared; all outputs are 0.
  - Reset during any state aborts it immediately, and no pulse is emitted.
- Interface:
  - key_valid is sampled on the rising edge of clk_in; key_code is only valid when key_valid=1.
  - At most one key per cycle is accepted; back-to-back keys are all accepted.
  - Ignored codes have no effect and do not restart the timeout.
- States: IDLE, ENTRY, UNLOCKED, SET_CODE, LOCKOUT.
- IDLE:
  - Digit -> store it, digit_count=1, go to ENTRY.
  - ENTER -> treated as a failed attempt (empty code).
  - CLEAR and SET are ignored.
- ENTRY:
  - Digit with digit_count<CODE_LEN -> shift into the buffer, digit_count+1.
  - Digit with digit_count=CODE_LEN -> the buffer is unchanged and an overflow flag is set.
  - CLEAR -> discard the buffer, go to IDLE, no fail counted.
  - ENTER -> compare the buffer with the stored code. The comparison is registered, so all outputs change on the cycle after ENTER is accepted.
    - Match requires digit_count=CODE_LEN, no overflow, and equal buffer: go to UNLOCKED, unlock=1, fail counter=0.
    - Otherwise: fail_pulse=1 for 1 cycle and the fail counter increments. If the counter reaches MAX_FAIL, go to LOCKOUT; else go to IDLE.
    - The buffer, digit_count and overflow flag are cleared in either case.
- Timeout:
  - In ENTRY or SET_CODE, a 28-bit idle counter restarts on every accepted key.
  - At TIMEOUT_CYCLES, discard the buffer and go to IDLE with no fail and no pulse.
- UNLOCKED:
  - unlock stays high for exactly UNLOCK_CYCLES cycles, then goes to IDLE.
  - CLEAR -> relock immediately (unlock=0 next cycle), go to IDLE.
  - SET -> go to SET_CODE; unlock drops the next cycle.
  - Digits and ENTER are ignored.
- SET_CODE: collects digits like ENTRY, including the overflow flag.
  - ENTER with exactly CODE_LEN digits and no overflow -> the stored code is updated, code_changed pulses, go to IDLE.
  - ENTER with any other length, or with overflow -> entry_error pulses, the code is unchanged, go to IDLE.
  - CLEAR -> abort to IDLE with no pulse.
  - No failure counting in this state.
- LOCKOUT:
  - lockout=1; all keys are ignored.
  - After LOCKOUT_CYCLES, go to IDLE; the fail counter clears and lockout=0.
- Simultaneous events:
  - A key arriving on the same cycle a timer expires: the timer wins and the key is dropped.
  - Same rule for the UNLOCK_CYCLES expiry with a SET key: the door relocks and SET is dropped.
- digit_count is 0 outside ENTRY and SET_CODE.
- All counters saturate; none wrap.

Decomposition:
- Shared package lock_pkg holds:
  - key code constants KEY_ENTER=4'hA, KEY_CLEAR=4'hB, KEY_SET=4'hC;
  - the state encoding constants.
- One sub-module, code_buffer:
  - shift-in digit register with digit_count, overflow flag, clear, and equality compare against a supplied code;
  - instantiated once and shared by ENTRY and SET_CODE.

Test Plan (UNLOCK_CYCLES=20, LOCKOUT_CYCLES=50, TIMEOUT_CYCLES=30, defaults otherwise):
- Keys 1,2,3,4,ENTER -> unlock=1 from the cycle after ENTER for exactly 20 cycles; fail_pulse stays 0.
- Keys 1,2,3,5,ENTER three times -> three fail_pulses; lockout=1 for 50 cycles. A correct code during lockout gives no unlock, and 1,2,3,4,ENTER after lockout unlocks.
- Keys 1,2,3,4,5,ENTER (overflow) -> fail_pulse; 1,2,ENTER -> fail_pulse.
- Key 1, then 30 idle cycles, then 2,3,4,ENTER -> fail_pulse, because the first digit was discarded.
- While unlocked: SET,9,8,7,6,ENTER -> code_changed. Then 1,2,3,4,ENTER fails and 9,8,7,6,ENTER unlocks. SET,9,8,ENTER -> entry_error, code unchanged.
- rst_n low mid-unlock after a code change -> unlock=0 immediately; 1,2,3,4,ENTER unlocks (DEFAULT_CODE restored).
